// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin arbiter/sequencer for a single-port RAM
//
// Purpose: serialises read/write requests from two clients onto one RAM port.
// Each transaction takes three cycles: IDLE (arbitrate) -> ACCESS (RAM
// address/data/strobe driven) -> ACK (one-cycle ack to the owner).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req0/we0/addr0/wdata0    requester 0 request, write enable, address, write data
//   ack0/rdata0              requester 0 completion pulse and read data
//   req1/we1/addr1/wdata1    requester 1 request, write enable, address, write data
//   ack1/rdata1              requester 1 completion pulse and read data
//   ram_wr/ram_addr/ram_wr_data  RAM write strobe, address, write data (registered)
//   ram_rd_data              RAM combinational read data
//   busy                     high whenever the sequencer is not in IDLE
//   gnt_cnt0/gnt_cnt1        saturating grant counters, present only with
//                            RAM_ARB_STATS_EN defined

module ram_arbiter #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wr_data,
  input  logic [DW-1:0] ram_rd_data,
  output logic          busy
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          owner;
  logic          last_owner;
  logic          grant;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Arbitration only looks at requests in IDLE; a request still held during
  // ACK is simply seen again once we are back in IDLE.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 && req1) begin
          grant      = ~last_owner;
          next_state = S_ACCESS;
        end else if (req0) begin
          grant      = 1'b0;
          next_state = S_ACCESS;
        end else if (req1) begin
          grant      = 1'b1;
          next_state = S_ACCESS;
        end
      end
      S_ACCESS: next_state = S_ACK;
      S_ACK:    next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  assign sel_we    = grant ? we1    : we0;
  assign sel_addr  = grant ? addr1  : addr0;
  assign sel_wdata = grant ? wdata1 : wdata0;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      ram_wr      <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else begin
      // Strobe and acks are single-cycle pulses; ram_addr/ram_wr_data hold.
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      ram_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (next_state == S_ACCESS) begin
            owner       <= grant;
            ram_addr    <= sel_addr;
            ram_wr_data <= sel_wdata;
            ram_wr      <= sel_we;
          end
        end
        S_ACCESS: begin
          ack0 <= ~owner;
          ack1 <= owner;
          // ram_wr still reflects the owner's write enable during ACCESS.
          if (!ram_wr) begin
            if (owner) begin
              rdata1 <= ram_rd_data;
            end else begin
              rdata0 <= ram_rd_data;
            end
          end
        end
        S_ACK: begin
          last_owner <= owner;
        end
        default: ;
      endcase
    end
  end

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (state == S_ACK) begin
      if (!owner && gnt_cnt0 != 16'hFFFF) begin
        gnt_cnt0 <= gnt_cnt0 + 16'd1;
      end
      if (owner && gnt_cnt1 != 16'hFFFF) begin
        gnt_cnt1 <= gnt_cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule
